// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared video timing defaults and pattern mode encodings
package video_timing_pkg;

  localparam int H_ACTIVE_DEFAULT = 800;
  localparam int V_ACTIVE_DEFAULT = 600;

  typedef enum logic [2:0] {
    MODE_PASS    = 3'd0,
    MODE_BARS    = 3'd1,
    MODE_RAMP    = 3'd2,
    MODE_CHECKER = 3'd3,
    MODE_GRID    = 3'd4,
    MODE_SOLID   = 3'd5,
    MODE_PASS_6  = 3'd6,
    MODE_PASS_7  = 3'd7
  } pattern_mode_e;

endpackage

// File: rtl/video_pattern_mux_if.sv
// rtl/video_pattern_mux_if.sv - pixel stream bundle: frame sync, active strobe and RGB data
interface video_pattern_mux_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  sync;
  logic                  active;
  logic [DATA_WIDTH-1:0] red;
  logic [DATA_WIDTH-1:0] green;
  logic [DATA_WIDTH-1:0] blue;

  modport master (output sync, active, red, green, blue);
  modport slave  (input  sync, active, red, green, blue);
endinterface

// File: rtl/video_pixel_coord.sv
// rtl/video_pixel_coord.sv - x/y pixel position, frame counter and sticky frame-geometry error
module video_pixel_coord #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 600,
  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  video_pattern_mux_if.slave       pix,
  output logic [XW-1:0]            cur_x,
  output logic [YW-1:0]            cur_y,
  output logic [15:0]              frame_count,
  output logic                     frame_error
);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic          frame_error_q, frame_error_d;
  logic          seen_sync_q, seen_sync_d;

  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    frame_count_d = frame_count_q;
    frame_error_d = frame_error_q;
    seen_sync_d   = seen_sync_q;
    cur_x         = pix.sync ? '0 : x_q;
    cur_y         = pix.sync ? '0 : y_q;

    // A well-formed frame leaves the counter parked at (0,0) when the next sync arrives.
    if (pix.sync) begin
      frame_count_d = frame_count_q + 16'd1;
      seen_sync_d   = 1'b1;
      if (seen_sync_q && ((x_q != '0) || (y_q != '0))) begin
        frame_error_d = 1'b1;
      end
      x_d = '0;
      y_d = '0;
    end

    if (pix.active) begin
      if (cur_x == XW'(H_ACTIVE - 1)) begin
        x_d = '0;
        y_d = (cur_y == YW'(V_ACTIVE - 1)) ? '0 : cur_y + YW'(1);
      end else begin
        x_d = cur_x + XW'(1);
        y_d = cur_y;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q           <= '0;
      y_q           <= '0;
      frame_count_q <= '0;
      frame_error_q <= 1'b0;
      seen_sync_q   <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      frame_count_q <= frame_count_d;
      frame_error_q <= frame_error_d;
      seen_sync_q   <= seen_sync_d;
    end
  end

  assign frame_count = frame_count_q;
  assign frame_error = frame_error_q;

endmodule

// File: rtl/video_pattern_mux.sv
// rtl/video_pattern_mux.sv - test-pattern generator muxed onto a pixel stream, two-stage pipeline
module video_pattern_mux
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEFAULT,
  parameter int V_ACTIVE   = V_ACTIVE_DEFAULT,
  parameter int DATA_WIDTH = 8,
  parameter int CHECK_LOG2 = 5
) (
  input  logic                    iClk,
  input  logic                    iRst,
  input  logic                    iPixelSync,
  input  logic                    iPixelActive,
  input  logic [DATA_WIDTH-1:0]   iDataRed,
  input  logic [DATA_WIDTH-1:0]   iDataGreen,
  input  logic [DATA_WIDTH-1:0]   iDataBlue,
  input  logic [2:0]              iMode,
  input  logic                    iScrollEn,
  input  logic [3*DATA_WIDTH-1:0] iSolidRgb,
  output logic                    oPixelSync,
  output logic                    oPixelActive,
  output logic [DATA_WIDTH-1:0]   oDataRed,
  output logic [DATA_WIDTH-1:0]   oDataGreen,
  output logic [DATA_WIDTH-1:0]   oDataBlue,
  output logic [15:0]             oFrameCount,
  output logic                    oFrameError
);

  localparam int XW  = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW  = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int XW1 = XW + 1;
  localparam int NW  = XW + ((DATA_WIDTH > 3) ? DATA_WIDTH : 3);
  localparam int NW1 = NW + 1;
  localparam int RW  = 2 * NW + 2;
  localparam longint unsigned RECIP_FULL = (64'd1 << NW) / 64'(H_ACTIVE);
  localparam logic [NW:0]     RECIP      = RECIP_FULL[NW:0];
  localparam int unsigned     CELL_MASK  = (32'd1 << CHECK_LOG2) - 32'd1;

  // n / H_ACTIVE via reciprocal multiply; the estimate is at most one low, fixed by one compare.
  function automatic logic [NW:0] div_by_h(input logic [NW-1:0] n);
    logic [RW-1:0] prod;
    logic [RW-1:0] rem;
    logic [NW:0]   q;
    prod = RW'(n) * RW'(RECIP);
    q    = NW1'(prod >> NW);
    rem  = RW'(n) - RW'(q) * RW'(H_ACTIVE);
    if (rem >= RW'(H_ACTIVE)) begin
      q = q + NW1'(1);
    end
    return q;
  endfunction

  video_pattern_mux_if #(.DATA_WIDTH(DATA_WIDTH)) pix_in ();

  assign pix_in.sync   = iPixelSync;
  assign pix_in.active = iPixelActive;
  assign pix_in.red    = iDataRed;
  assign pix_in.green  = iDataGreen;
  assign pix_in.blue   = iDataBlue;

  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;

  video_pixel_coord #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_coord (
    .clk         (iClk),
    .rst         (iRst),
    .pix         (pix_in),
    .cur_x       (cur_x),
    .cur_y       (cur_y),
    .frame_count (oFrameCount),
    .frame_error (oFrameError)
  );

  pattern_mode_e           mode_q, mode_d;
  logic [XW-1:0]           offset_q, offset_d;
  logic [XW:0]             x_sum;
  logic                    s1_sync_q, s1_sync_d;
  logic                    s1_active_q, s1_active_d;
  pattern_mode_e           s1_mode_q, s1_mode_d;
  logic [XW-1:0]           s1_x_q, s1_x_d;
  logic [XW-1:0]           s1_xe_q, s1_xe_d;
  logic [YW-1:0]           s1_y_q, s1_y_d;
  logic [DATA_WIDTH-1:0]   s1_red_q, s1_red_d;
  logic [DATA_WIDTH-1:0]   s1_green_q, s1_green_d;
  logic [DATA_WIDTH-1:0]   s1_blue_q, s1_blue_d;
  logic [3*DATA_WIDTH-1:0] s1_solid_q, s1_solid_d;

  // Mode and scroll update on the sync pixel itself so the whole frame sees one setting.
  always_comb begin
    mode_d   = mode_q;
    offset_d = offset_q;
    if (pix_in.sync) begin
      mode_d = pattern_mode_e'(iMode);
      if (iScrollEn) begin
        offset_d = (offset_q == XW'(H_ACTIVE - 1)) ? '0 : offset_q + XW'(1);
      end
    end
    x_sum       = {1'b0, cur_x} + {1'b0, offset_d};
    s1_xe_d     = (x_sum >= XW1'(H_ACTIVE)) ? XW'(x_sum - XW1'(H_ACTIVE)) : XW'(x_sum);
    s1_sync_d   = pix_in.sync;
    s1_active_d = pix_in.active;
    s1_mode_d   = mode_d;
    s1_x_d      = cur_x;
    s1_y_d      = cur_y;
    s1_red_d    = pix_in.red;
    s1_green_d  = pix_in.green;
    s1_blue_d   = pix_in.blue;
    s1_solid_d  = iSolidRgb;
  end

  logic [2:0]            bar_idx;
  logic [DATA_WIDTH-1:0] ramp_val;
  logic                  checker_on;
  logic                  grid_on;
  logic                  out_sync_q, out_sync_d;
  logic                  out_active_q, out_active_d;
  logic [DATA_WIDTH-1:0] out_red_q, out_red_d;
  logic [DATA_WIDTH-1:0] out_green_q, out_green_d;
  logic [DATA_WIDTH-1:0] out_blue_q, out_blue_d;

  always_comb begin
    bar_idx    = 3'(div_by_h(NW'(s1_xe_q) << 3));
    ramp_val   = DATA_WIDTH'(div_by_h(NW'(s1_xe_q) << DATA_WIDTH));
    checker_on = (((32'(s1_xe_q) >> CHECK_LOG2) ^ (32'(s1_y_q) >> CHECK_LOG2)) & 32'd1) != 32'd0;
    grid_on    = (s1_x_q == '0) || (s1_x_q == XW'(H_ACTIVE - 1)) ||
                 (s1_y_q == '0) || (s1_y_q == YW'(V_ACTIVE - 1)) ||
                 ((32'(s1_x_q) & CELL_MASK) == 32'd0) ||
                 ((32'(s1_y_q) & CELL_MASK) == 32'd0);

    out_sync_d   = s1_sync_q;
    out_active_d = s1_active_q;
    out_red_d    = '0;
    out_green_d  = '0;
    out_blue_d   = '0;
    if (s1_active_q) begin
      case (s1_mode_q)
        MODE_BARS: begin
          out_red_d   = {DATA_WIDTH{~bar_idx[1]}};
          out_green_d = {DATA_WIDTH{~bar_idx[2]}};
          out_blue_d  = {DATA_WIDTH{~bar_idx[0]}};
        end
        MODE_RAMP: begin
          out_red_d   = ramp_val;
          out_green_d = ramp_val;
          out_blue_d  = ramp_val;
        end
        MODE_CHECKER: begin
          out_red_d   = {DATA_WIDTH{checker_on}};
          out_green_d = {DATA_WIDTH{checker_on}};
          out_blue_d  = {DATA_WIDTH{checker_on}};
        end
        MODE_GRID: begin
          out_red_d   = {DATA_WIDTH{grid_on}};
          out_green_d = {DATA_WIDTH{grid_on}};
          out_blue_d  = {DATA_WIDTH{grid_on}};
        end
        MODE_SOLID: {out_red_d, out_green_d, out_blue_d} = s1_solid_q;
        default: begin
          out_red_d   = s1_red_q;
          out_green_d = s1_green_q;
          out_blue_d  = s1_blue_q;
        end
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      mode_q       <= MODE_PASS;
      offset_q     <= '0;
      s1_sync_q    <= 1'b0;
      s1_active_q  <= 1'b0;
      s1_mode_q    <= MODE_PASS;
      s1_x_q       <= '0;
      s1_xe_q      <= '0;
      s1_y_q       <= '0;
      s1_red_q     <= '0;
      s1_green_q   <= '0;
      s1_blue_q    <= '0;
      s1_solid_q   <= '0;
      out_sync_q   <= 1'b0;
      out_active_q <= 1'b0;
      out_red_q    <= '0;
      out_green_q  <= '0;
      out_blue_q   <= '0;
    end else begin
      mode_q       <= mode_d;
      offset_q     <= offset_d;
      s1_sync_q    <= s1_sync_d;
      s1_active_q  <= s1_active_d;
      s1_mode_q    <= s1_mode_d;
      s1_x_q       <= s1_x_d;
      s1_xe_q      <= s1_xe_d;
      s1_y_q       <= s1_y_d;
      s1_red_q     <= s1_red_d;
      s1_green_q   <= s1_green_d;
      s1_blue_q    <= s1_blue_d;
      s1_solid_q   <= s1_solid_d;
      out_sync_q   <= out_sync_d;
      out_active_q <= out_active_d;
      out_red_q    <= out_red_d;
      out_green_q  <= out_green_d;
      out_blue_q   <= out_blue_d;
    end
  end

  assign oPixelSync   = out_sync_q;
  assign oPixelActive = out_active_q;
  assign oDataRed     = out_red_q;
  assign oDataGreen   = out_green_q;
  assign oDataBlue    = out_blue_q;

endmodule

// File: tb/tb_video_pattern_mux.sv
// tb/tb_video_pattern_mux.sv - randomized pixel-stream bench with a behavioural pattern model
module tb_video_pattern_mux;

  localparam int H  = 16;
  localparam int V  = 4;
  localparam int CL = 2;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  mode_in;
  logic        scroll_en;
  logic [23:0] solid;
  logic [15:0] fcount, fcount2;
  logic        ferr, ferr2;
  logic [2:0]  mode2_in;
  logic        scroll2_en;
  logic [23:0] solid2;

  video_pattern_mux_if #(.DATA_WIDTH(DW)) pin ();
  video_pattern_mux_if #(.DATA_WIDTH(DW)) pout ();
  video_pattern_mux_if #(.DATA_WIDTH(8))  pin2 ();
  video_pattern_mux_if #(.DATA_WIDTH(8))  pout2 ();

  video_pattern_mux #(
    .H_ACTIVE(H), .V_ACTIVE(V), .DATA_WIDTH(DW), .CHECK_LOG2(CL)
  ) dut (
    .iClk(clk), .iRst(rst),
    .iPixelSync(pin.sync), .iPixelActive(pin.active),
    .iDataRed(pin.red), .iDataGreen(pin.green), .iDataBlue(pin.blue),
    .iMode(mode_in), .iScrollEn(scroll_en), .iSolidRgb(solid),
    .oPixelSync(pout.sync), .oPixelActive(pout.active),
    .oDataRed(pout.red), .oDataGreen(pout.green), .oDataBlue(pout.blue),
    .oFrameCount(fcount), .oFrameError(ferr)
  );

  video_pattern_mux #(.DATA_WIDTH(8)) dut2 (
    .iClk(clk), .iRst(rst),
    .iPixelSync(pin2.sync), .iPixelActive(pin2.active),
    .iDataRed(pin2.red), .iDataGreen(pin2.green), .iDataBlue(pin2.blue),
    .iMode(mode2_in), .iScrollEn(scroll2_en), .iSolidRgb(solid2),
    .oPixelSync(pout2.sync), .oPixelActive(pout2.active),
    .oDataRed(pout2.red), .oDataGreen(pout2.green), .oDataBlue(pout2.blue),
    .oFrameCount(fcount2), .oFrameError(ferr2)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [23:0] pattern(input int mode, input int xe, input int x, input int y,
                                          input logic [23:0] src, input logic [23:0] sol);
    int i;
    logic [7:0] r, g, b;
    case (mode)
      1: begin
        i = (xe * 8) / H;
        r = (((i / 2) % 2) != 0) ? 8'h00 : 8'hff;
        g = (((i / 4) % 2) != 0) ? 8'h00 : 8'hff;
        b = ((i % 2) != 0) ? 8'h00 : 8'hff;
        return {r, g, b};
      end
      2: begin
        i = (xe * 256) / H;
        return {3{8'(i)}};
      end
      3: return ((((xe / (1 << CL)) + (y / (1 << CL))) % 2) != 0) ? 24'hffffff : 24'h0;
      4: return (x == 0 || x == H - 1 || y == 0 || y == V - 1 ||
                 (x % (1 << CL)) == 0 || (y % (1 << CL)) == 0) ? 24'hffffff : 24'h0;
      5: return sol;
      default: return src;
    endcase
  endfunction

  // Reference model: position, latched mode, scroll and frame bookkeeping from the rules directly.
  int          mx, my, mmode, moff;
  bit          mseen;
  logic [15:0] mcnt;
  logic        merr;
  logic [25:0] exp_pipe1, exp_out;

  always @(posedge clk) begin
    logic [23:0] d;
    if (rst) begin
      mx = 0; my = 0; mmode = 0; moff = 0; mseen = 0; mcnt = 16'd0; merr = 1'b0;
      exp_pipe1 = '0; exp_out = '0;
    end else begin
      if (pin.sync) begin
        if (mseen && (mx != 0 || my != 0)) merr = 1'b1;
        mseen = 1;
        mcnt  = mcnt + 16'd1;
        mmode = int'(mode_in);
        if (scroll_en) moff = (moff + 1) % H;
        mx = 0; my = 0;
      end
      d = 24'h0;
      if (pin.active) begin
        d = pattern(mmode, (mx + moff) % H, mx, my, {pin.red, pin.green, pin.blue}, solid);
        mx++;
        if (mx == H) begin mx = 0; my = (my + 1) % V; end
      end
      exp_out   = exp_pipe1;
      exp_pipe1 = {pin.sync, pin.active, d};
    end
  end

  bit checking = 0;
  always @(negedge clk) begin
    if (checking) begin
      check("pixel_out", 32'({pout.sync, pout.active, pout.red, pout.green, pout.blue}), 32'(exp_out));
      check("frame_count", 32'(fcount), 32'(mcnt));
      check("frame_error", 32'(ferr), 32'(merr));
    end
  end

  bit          watch = 0;
  int          widx  = 0;
  logic [23:0] wbuf [16];
  always @(negedge clk) begin
    if (watch && pout.active === 1'b1 && widx < 16) begin
      wbuf[widx] = {pout.red, pout.green, pout.blue};
      widx++;
    end
  end

  int d2_idx = 0;
  always @(negedge clk) begin
    if (pout2.active === 1'b1) begin
      case (d2_idx)
        0:   check("dflt_ramp_x0",   32'({pout2.red, pout2.green, pout2.blue}), 32'h000000);
        400: check("dflt_ramp_x400", 32'({pout2.red, pout2.green, pout2.blue}), 32'h808080);
        799: check("dflt_ramp_x799", 32'({pout2.red, pout2.green, pout2.blue}), 32'hffffff);
        default: ;
      endcase
      d2_idx++;
    end
  end

  task automatic pixel(input logic s, input logic a);
    @(negedge clk);
    pin.sync   = s;
    pin.active = a;
    pin.red    = 8'($urandom);
    pin.green  = 8'($urandom);
    pin.blue   = 8'($urandom);
    solid      = 24'($urandom);
  endtask

  task automatic pixel2(input logic s, input logic a);
    @(negedge clk);
    pin2.sync   = s;
    pin2.active = a;
    pin2.red    = 8'($urandom);
    pin2.green  = 8'($urandom);
    pin2.blue   = 8'($urandom);
  endtask

  task automatic frame(input int lines, input int gap_pct, input int chg_at, input logic [2:0] chg_mode);
    for (int p = 0; p < lines * H; p++) begin
      if (p == chg_at) mode_in = chg_mode;
      if ($urandom_range(99) < gap_pct) pixel(1'b0, 1'b0);
      pixel(p == 0, 1'b1);
    end
  endtask

  task automatic start_watch();
    repeat (3) pixel(1'b0, 1'b0);
    widx  = 0;
    watch = 1;
  endtask

  task automatic stop_watch();
    repeat (3) pixel(1'b0, 1'b0);
    watch = 0;
  endtask

  initial begin
    rst = 1'b1; mode_in = 3'd0; scroll_en = 1'b0; solid = 24'h0;
    pin.sync = 0; pin.active = 0; pin.red = 0; pin.green = 0; pin.blue = 0;
    pin2.sync = 0; pin2.active = 0; pin2.red = 0; pin2.green = 0; pin2.blue = 0;
    mode2_in = 3'd2; scroll2_en = 1'b0; solid2 = 24'h0;
    repeat (3) pixel(1'b0, 1'b0);
    rst = 1'b0;
    checking = 1;
    check("rst_frame_count", 32'(fcount), 32'd0);
    check("rst_frame_error", 32'(ferr), 32'd0);
    check("rst_pixel", 32'({pout.sync, pout.active, pout.red, pout.green, pout.blue}), 32'd0);

    check("model_bar_x0",  32'(pattern(1, 0, 0, 0, 0, 0)),  32'hffffff);
    check("model_bar_x2",  32'(pattern(1, 2, 2, 0, 0, 0)),  32'hffff00);
    check("model_bar_x4",  32'(pattern(1, 4, 4, 0, 0, 0)),  32'h00ffff);
    check("model_bar_x12", 32'(pattern(1, 12, 12, 0, 0, 0)), 32'h0000ff);
    check("model_ramp_x8", 32'(pattern(2, 8, 8, 0, 0, 0)),  32'h808080);
    check("model_grid_51", 32'(pattern(4, 5, 5, 1, 0, 0)),  32'h000000);
    check("model_chk_41",  32'(pattern(3, 4, 4, 1, 0, 0)),  32'hffffff);

    // Mode requested before any sync must stay passthrough.
    mode_in = 3'd3;
    for (int i = 0; i < 10; i++) pixel(1'b0, 1'($urandom_range(1)));

    mode_in = 3'd1;
    start_watch();
    frame(4, 0, -1, 3'd0);
    stop_watch();
    check("bars_x0",  32'(wbuf[0]),  32'hffffff);
    check("bars_x1",  32'(wbuf[1]),  32'hffffff);
    check("bars_x2",  32'(wbuf[2]),  32'hffff00);
    check("bars_x4",  32'(wbuf[4]),  32'h00ffff);
    check("bars_x15", 32'(wbuf[15]), 32'h000000);

    mode_in = 3'd3; scroll_en = 1'b1;
    frame(4, 20, -1, 3'd0);
    frame(4, 20, -1, 3'd0);
    frame(4, 20, 30, 3'd4);
    frame(4, 20, -1, 3'd0);
    scroll_en = 1'b0;
    for (int m = 0; m < 8; m++) begin
      mode_in = 3'(m);
      frame(4, 30, -1, 3'd0);
    end
    for (int i = 0; i < 40; i++) pixel(1'b0, 1'b0);

    mode_in = 3'd1;
    frame(2, 10, -1, 3'd0);
    check("err_before_sync", 32'(ferr), 32'd0);
    frame(4, 10, -1, 3'd0);
    check("err_after_short", 32'(ferr), 32'd1);
    frame(4, 10, -1, 3'd0);
    frame(4, 10, -1, 3'd0);
    check("err_sticky", 32'(ferr), 32'd1);

    mode_in = 3'd2;
    for (int p = 0; p < 39; p++) pixel(p == 0, 1'b1);
    pixel(1'b0, 1'b1);
    rst = 1'b1;
    pixel(1'b0, 1'b1);
    rst = 1'b0;
    check("rst_mid_pixel", 32'({pout.sync, pout.active, pout.red, pout.green, pout.blue}), 32'd0);
    check("rst_mid_count", 32'(fcount), 32'd0);
    check("rst_mid_error", 32'(ferr), 32'd0);
    for (int p = 41; p < 64; p++) pixel(1'b0, 1'b1);
    start_watch();
    frame(4, 0, -1, 3'd0);
    stop_watch();
    check("ramp_x0",  32'(wbuf[0]),  32'h000000);
    check("ramp_x8",  32'(wbuf[8]),  32'h808080);
    check("ramp_x15", 32'(wbuf[15]), 32'hf0f0f0);

    for (int p = 0; p < 800; p++) pixel2(p == 0, 1'b1);
    repeat (4) pixel2(1'b0, 1'b0);
    check("dflt_pixel_count", 32'(d2_idx), 32'd800);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
